udp_echo_responder: RTL and testbench
=====================================

Name: udp_echo_responder

Overview:
- Application-side endpoint of the UDPv4 bus: consumes the L4 RX bus from the UDP protocol block and drives its L4 TX bus.
- Captures one datagram addressed to LISTEN_PORT into a single packet buffer. Once the datagram is committed, echoes the payload back to the sender with the ports swapped.
- Acts as the reference UDP application for bring-up, loopback and throughput tests.

Parameters:
- LISTEN_PORT, 16'd7, UDP destination port that is accepted; becomes the source port of the reply.
- MAX_WORDS, 256, buffer depth in 32-bit words; max payload = 4*MAX_WORDS bytes.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_l4_bus  in  $bits(UDPv4RxBus)  datagrams from the UDP protocol block (start/data_valid/bytes_valid/data/commit/drop, src_ip, src_port, dst_port, payload_len).
- tx_l4_bus  out  $bits(UDPv4TxBus)  replies to the UDP protocol block.
- busy  out  1  high from capture start until reply commit.

Behaviour:
- Reset: all tx_l4_bus fields 0, busy 0, both state machines to idle, buffer marked empty. Buffer RAM contents are don't-care. Reset mid-packet abandons the packet with no drop or commit issued.
- RX FSM states: RX_IDLE, RX_CAPTURE, RX_HOLD.
  - RX_IDLE: on start, capture the packet only if all of these hold: dst_port == LISTEN_PORT, payload_len <= 4*MAX_WORDS, and TX FSM is TX_IDLE. On capture: latch src_ip, src_port and payload_len, clear wr_ptr, go to RX_CAPTURE. Otherwise stay in RX_IDLE and ignore the packet.
  - RX_CAPTURE: each data_valid writes data to buffer[wr_ptr], increments wr_ptr and adds bytes_valid to byte_cnt. Writes are suppressed once wr_ptr == MAX_WORDS.
    - On commit, if byte_cnt == payload_len, go to RX_HOLD; otherwise go to RX_IDLE and discard.
    - On drop, go to RX_IDLE and discard. Drop takes priority over data or commit in the same cycle.
  - RX_HOLD: wait one cycle for TX to latch, then go to RX_IDLE. No new capture is possible until TX returns to TX_IDLE.
- TX FSM states: TX_IDLE, TX_START, TX_DATA, TX_COMMIT.
  - TX_IDLE -> TX_START when RX enters RX_HOLD.
  - TX_START: pulse start for 1 cycle with:
    - dst_ip = latched src_ip
    - dst_port = latched src_port
    - src_port = LISTEN_PORT
    - payload_len = latched payload_len
  - Header fields stay stable until commit.
  - TX_DATA: buffer reads are registered (1-cycle latency); issue the read for word 0 in TX_START.
    - data_valid asserts on consecutive cycles starting the cycle after start, with no gaps, for ceil(payload_len/4) words.
    - bytes_valid = 4 except on the last word, which carries payload_len[1:0], with 0 mapping to 4.
  - TX_COMMIT: pulse commit for 1 cycle, in the cycle after the last data word. Then go to TX_IDLE and clear busy.
  - Zero-length payload: start, then commit on the next cycle, with no data cycles.
- Width rules:
  - byte_cnt is 16 bits; it saturates and cannot wrap for legal payload_len.
  - Word count = (payload_len + 3) >> 2, computed in 17 bits.
- Simultaneous events: an rx start that arrives while TX is active, or in the same cycle as TX_COMMIT, is ignored. tx drop is never asserted.

Optional Feature:
- Macro: UDP_ECHO_STATS_EN.
- Defined: adds 32-bit saturating outputs, all cleared by rst:
  - stat_rx_ok: each capture reaching RX_HOLD.
  - stat_rx_busy: each port-matched start ignored because TX was not idle.
  - stat_rx_bad: each port-matched start rejected as oversized, or capture discarded by drop or length mismatch.
  - stat_tx: each reply commit.
- Undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- No new package entries: reuse UDPv4RxBus and UDPv4TxBus from the existing bus headers.
- Add RX/TX state enums locally.
- Sub-module udp_echo_buffer: simple dual-port RAM, MAX_WORDS x 32, one write port and one registered read port, no reset on contents.

Test Plan:
- Port 7, src 10.0.0.2:5000, payload_len 8, words 0x01020304 and 0x05060708, commit -> tx start with dst 10.0.0.2:5000, src_port 7, len 8. Same two words follow on the next two cycles with bytes_valid 4, 4; commit on the cycle after.
- payload_len 5 (words 0xAABBCCDD, 0xEE000000 with bytes_valid 1) -> reply has 2 words, last bytes_valid 1; payload_len 0 -> start then commit with no data.
- dst_port 53 -> no tx activity, busy stays 0. payload_len 4*MAX_WORDS+1 on port 7 -> ignored (stat_rx_bad +1 with UDP_ECHO_STATS_EN).
- rx drop mid-capture after 2 of 4 words, then a valid 4-byte datagram -> only the second datagram is echoed. Commit with byte_cnt 4 vs payload_len 8 -> no reply.
- Second datagram arriving while a reply is in TX_DATA -> ignored, stat_rx_busy +1; the first reply completes intact.
- rst asserted during TX_DATA -> next cycle all tx fields 0, busy 0, no commit. A fresh datagram afterwards is echoed normally.

Source files
------------

// File: rtl/udp_echo_responder_pkg.sv
// udp_echo_responder_pkg: UDPv4 L4 bus payloads shared by the UDP protocol
// block and its applications, plus small helpers used by the echo responder.
// No ports; import with udp_echo_responder_pkg::*.
package udp_echo_responder_pkg;

  localparam int unsigned DATA_W = 32;

  // Datagram stream from the UDP protocol block to an application.
  typedef struct packed {
    logic              start;
    logic              data_valid;
    logic [2:0]        bytes_valid;
    logic [DATA_W-1:0] data;
    logic              commit;
    logic              drop;
    logic [31:0]       src_ip;
    logic [15:0]       src_port;
    logic [15:0]       dst_port;
    logic [15:0]       payload_len;
  } UDPv4RxBus;

  // Datagram stream from an application to the UDP protocol block.
  typedef struct packed {
    logic              start;
    logic              data_valid;
    logic [2:0]        bytes_valid;
    logic [DATA_W-1:0] data;
    logic              commit;
    logic              drop;
    logic [31:0]       dst_ip;
    logic [15:0]       dst_port;
    logic [15:0]       src_port;
    logic [15:0]       payload_len;
  } UDPv4TxBus;

  localparam int unsigned RX_BUS_W = $bits(UDPv4RxBus);
  localparam int unsigned TX_BUS_W = $bits(UDPv4TxBus);

  // Valid bytes in the final word of a payload; a multiple of 4 fills it.
  function automatic logic [2:0] tail_bytes(input logic [15:0] len);
    return (len[1:0] == 2'd0) ? 3'd4 : {1'b0, len[1:0]};
  endfunction

endpackage

// File: rtl/udp_echo_buffer.sv
// udp_echo_buffer: single-packet payload store for the echo responder.
// Simple dual-port RAM, MAX_WORDS x 32, one write port and one read port
// with a registered output. Contents are not reset.
// Ports:
//   clk      system clock
//   wr_en    write strobe, wr_addr/wr_data written on the rising edge
//   rd_en    read strobe, rd_data updates on the following edge
//   rd_data  registered read data (holds when rd_en is low)
module udp_echo_buffer
  import udp_echo_responder_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [MAX_WORDS];

  // Write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/udp_echo_responder.sv
// udp_echo_responder: reference UDP application. Captures one datagram sent
// to LISTEN_PORT into a single packet buffer and, once committed, echoes the
// payload back to the sender with the ports swapped.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset
//   rx_l4_bus  UDPv4RxBus from the UDP protocol block
//   tx_l4_bus  UDPv4TxBus replies to the UDP protocol block (drop never set)
//   busy       high from capture start until the reply commit
// Build option UDP_ECHO_STATS_EN adds 32-bit saturating counters
//   stat_rx_ok, stat_rx_busy, stat_rx_bad, stat_tx (cleared by rst).
module udp_echo_responder
  import udp_echo_responder_pkg::*;
#(
  parameter logic [15:0] LISTEN_PORT = 16'd7,
  parameter int unsigned MAX_WORDS   = 256
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RX_BUS_W-1:0] rx_l4_bus,
  output logic [TX_BUS_W-1:0] tx_l4_bus,
  output logic                busy
`ifdef UDP_ECHO_STATS_EN
  ,
  output logic [31:0]         stat_rx_ok,
  output logic [31:0]         stat_rx_busy,
  output logic [31:0]         stat_rx_bad,
  output logic [31:0]         stat_tx
`endif
);

  localparam int unsigned AW        = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int unsigned PW        = $clog2(MAX_WORDS + 1);
  localparam logic [16:0] MAX_BYTES = 17'(4 * MAX_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_CAPTURE, RX_HOLD} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_COMMIT} tx_state_e;

  UDPv4RxBus rx;
  assign rx = rx_l4_bus;

  rx_state_e rx_state, rx_next;
  tx_state_e tx_state, tx_next;

  logic [31:0]       lat_ip;
  logic [15:0]       lat_port;
  logic [15:0]       lat_len;
  logic [PW-1:0]     wr_ptr;
  logic [15:0]       byte_cnt;
  logic [16:0]       byte_sum;
  logic [15:0]       byte_cnt_nx;
  logic              port_hit;
  logic              len_ok;
  logic              accept;
  logic              buf_full;
  logic              wr_en;

  logic [16:0]       word_cnt;
  logic [16:0]       sent;
  logic [16:0]       sent_nx;
  logic [AW-1:0]     rd_addr;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;

  UDPv4TxBus         tx_d, tx_q, tx_out;
  logic              busy_d;

  // Capture qualification for a start seen while idle.
  assign port_hit = rx.start && (rx.dst_port == LISTEN_PORT);
  assign len_ok   = 17'(rx.payload_len) <= MAX_BYTES;
  assign accept   = (rx_state == RX_IDLE) && port_hit && len_ok && (tx_state == TX_IDLE);
  assign buf_full = (wr_ptr == PW'(MAX_WORDS));

  // Byte count saturates at 16 bits; a beat arriving with commit is counted.
  assign byte_sum    = 17'(byte_cnt) + 17'(rx.bytes_valid);
  assign byte_cnt_nx = !rx.data_valid ? byte_cnt :
                       (byte_sum[16] ? 16'hFFFF : byte_sum[15:0]);

  // Words to replay, kept in 17 bits so a 0xFFFF length cannot wrap.
  assign word_cnt = (17'(lat_len) + 17'd3) >> 2;
  assign sent_nx  = (tx_state == TX_DATA) ? (sent + 17'd1) : 17'd0;

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      tx_state <= TX_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  // RX next state; drop outranks data and commit.
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE: begin
        if (accept) rx_next = RX_CAPTURE;
      end
      RX_CAPTURE: begin
        if (rx.drop) begin
          rx_next = RX_IDLE;
        end else if (rx.commit) begin
          rx_next = (byte_cnt_nx == lat_len) ? RX_HOLD : RX_IDLE;
        end
      end
      RX_HOLD: rx_next = RX_IDLE;
      default: rx_next = RX_IDLE;
    endcase
  end

  // TX next state.
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE: begin
        if (rx_state == RX_HOLD) tx_next = TX_START;
      end
      TX_START: tx_next = (word_cnt == 17'd0) ? TX_COMMIT : TX_DATA;
      TX_DATA: begin
        if ((sent + 17'd1) == word_cnt) tx_next = TX_COMMIT;
      end
      TX_COMMIT: tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  // Buffer port controls: word 0 is read in TX_START, then one read per
  // data cycle so the registered RAM output lines up with data_valid.
  always_comb begin
    wr_en = (rx_state == RX_CAPTURE) && rx.data_valid && !rx.drop && !buf_full;
    rd_en = (tx_state == TX_START) ||
            ((tx_state == TX_DATA) && ((sent + 17'd1) < word_cnt));
  end

  // Output register inputs, decoded from the next TX state.
  always_comb begin
    tx_d   = '0;
    busy_d = (rx_next != RX_IDLE) || (tx_next != TX_IDLE);
    if (tx_next != TX_IDLE) begin
      tx_d.dst_ip      = lat_ip;
      tx_d.dst_port    = lat_port;
      tx_d.src_port    = LISTEN_PORT;
      tx_d.payload_len = lat_len;
    end
    tx_d.start  = (tx_next == TX_START);
    tx_d.commit = (tx_next == TX_COMMIT);
    if (tx_next == TX_DATA) begin
      tx_d.data_valid  = 1'b1;
      tx_d.bytes_valid = ((sent_nx + 17'd1) == word_cnt) ? tail_bytes(lat_len) : 3'd4;
    end
  end

  // Capture datapath and header latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_ip   <= '0;
      lat_port <= '0;
      lat_len  <= '0;
      wr_ptr   <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      lat_ip   <= rx.src_ip;
      lat_port <= rx.src_port;
      lat_len  <= rx.payload_len;
      wr_ptr   <= '0;
      byte_cnt <= '0;
    end else if ((rx_state == RX_CAPTURE) && rx.data_valid && !rx.drop) begin
      byte_cnt <= byte_cnt_nx;
      if (!buf_full) wr_ptr <= wr_ptr + PW'(1);
    end
  end

  // Replay pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sent    <= '0;
      rd_addr <= '0;
      tx_q    <= '0;
      busy    <= 1'b0;
    end else begin
      sent <= sent_nx;
      if (tx_state == TX_IDLE) begin
        rd_addr <= '0;
      end else if (rd_en) begin
        rd_addr <= rd_addr + AW'(1);
      end
      tx_q <= tx_d;
      busy <= busy_d;
    end
  end

  // Payload comes straight from the RAM output register, zero when idle.
  always_comb begin
    tx_out      = tx_q;
    tx_out.data = tx_q.data_valid ? rd_data : '0;
  end
  assign tx_l4_bus = tx_out;

  udp_echo_buffer #(
    .MAX_WORDS (MAX_WORDS),
    .AW        (AW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (rx.data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

`ifdef UDP_ECHO_STATS_EN
  logic ev_ok, ev_busy, ev_bad, ev_tx;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  // Busy rejections win over size rejections when both apply.
  always_comb begin
    ev_ok   = (rx_state == RX_CAPTURE) && (rx_next == RX_HOLD);
    ev_busy = (rx_state == RX_IDLE) && port_hit && (tx_state != TX_IDLE);
    ev_bad  = ((rx_state == RX_IDLE) && port_hit && (tx_state == TX_IDLE) && !len_ok) ||
              ((rx_state == RX_CAPTURE) && (rx_next == RX_IDLE));
    ev_tx   = (tx_state == TX_COMMIT);
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_rx_ok   <= '0;
      stat_rx_busy <= '0;
      stat_rx_bad  <= '0;
      stat_tx      <= '0;
    end else begin
      if (ev_ok)   stat_rx_ok   <= sat_inc(stat_rx_ok);
      if (ev_busy) stat_rx_busy <= sat_inc(stat_rx_busy);
      if (ev_bad)  stat_rx_bad  <= sat_inc(stat_rx_bad);
      if (ev_tx)   stat_tx      <= sat_inc(stat_tx);
    end
  end
`endif

endmodule

// File: tb/tb_udp_echo_responder.sv
// tb_udp_echo_responder: scoreboard bench for udp_echo_responder. Stimulus
// pushes expected reply events; an independent monitor pops and compares.
module tb_udp_echo_responder;
  import udp_echo_responder_pkg::*;

  typedef struct {
    logic [2:0]  flags;   // {start, data_valid, commit}
    logic [31:0] data;
    logic [2:0]  bv;
    logic [31:0] ip;
    logic [15:0] dport;
    logic [15:0] len;
    bit          follows; // must appear the cycle after the previous event
  } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  UDPv4RxBus           rx_drv = '0;
  logic [TX_BUS_W-1:0] tx_bus;
  logic                busy;
`ifdef UDP_ECHO_STATS_EN
  logic [31:0] s_ok, s_busy, s_bad, s_tx;
`endif

  int  checks = 0;
  int  errors = 0;
  ev_t exp_q[$];
  bit  busy_seen = 0;
  int  m_ok = 0, m_busy = 0, m_bad = 0, m_tx = 0;

  always #5 clk = ~clk;

  udp_echo_responder #(.LISTEN_PORT(16'd7), .MAX_WORDS(256)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_l4_bus (rx_drv),
    .tx_l4_bus (tx_bus),
    .busy      (busy)
`ifdef UDP_ECHO_STATS_EN
    ,
    .stat_rx_ok   (s_ok),
    .stat_rx_busy (s_busy),
    .stat_rx_bad  (s_bad),
    .stat_tx      (s_tx)
`endif
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: every cycle with tx activity consumes one expected event.
  initial begin : monitor
    UDPv4TxBus t;
    ev_t       e;
    bit        ok;
    int        cyc = 0;
    int        last_cyc = -10;
    forever begin
      @(negedge clk);
      cyc++;
      busy_seen = busy_seen | busy;
      t = tx_bus;
      if (!rst && (t.start || t.data_valid || t.commit || t.drop)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL tx_unexpected flags=%b drop=%b data=%h", {t.start, t.data_valid, t.commit}, t.drop, t.data);
        end else begin
          e  = exp_q.pop_front();
          ok = ({t.start, t.data_valid, t.commit} == e.flags) && !t.drop &&
               (t.dst_ip == e.ip) && (t.dst_port == e.dport) &&
               (t.src_port == 16'd7) && (t.payload_len == e.len);
          if (e.flags == 3'b010) ok = ok && (t.data == e.data) && (t.bytes_valid == e.bv);
          if (e.follows && (cyc != last_cyc + 1)) ok = 0;
          if (!ok) begin
            errors++;
            $display("FAIL tx_event got flags=%b data=%h bv=%0d ip=%h dp=%0d sp=%0d len=%0d gap=%0d exp flags=%b data=%h bv=%0d ip=%h dp=%0d len=%0d",
                     {t.start, t.data_valid, t.commit}, t.data, t.bytes_valid, t.dst_ip, t.dst_port,
                     t.src_port, t.payload_len, cyc - last_cyc, e.flags, e.data, e.bv, e.ip, e.dport, e.len);
          end
        end
        last_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  // Drive one datagram and record what the reply must look like.
  // mode 0: normal, 1: drop on beat 'cut', 2: commit after only 'cut' beats.
  task automatic send_dgram(input logic [15:0] dport, input logic [31:0] ip, input logic [15:0] sport,
                            input logic [15:0] len, input int mode, input int cut, input bit tx_busy,
                            input bit fixed, input logic [31:0] w0, input logic [31:0] w1);
    int          nb, nsend;
    bit          cap, echo, dropped;
    logic [31:0] w[$];
    logic [2:0]  tail;
    ev_t         e;
    UDPv4RxBus   base;
    nb    = (int'(len) + 3) / 4;
    cap   = (dport == 16'd7) && (len <= 16'd1024) && !tx_busy;
    echo  = cap && (mode == 0);
    nsend = cap ? nb : ((nb < 6) ? nb : 6);
    tail  = (len % 4 == 0) ? 3'd4 : 3'(len % 4);
    for (int i = 0; i < nb; i++) w.push_back($urandom);
    if (fixed && nb > 0) w[0] = w0;
    if (fixed && nb > 1) w[1] = w1;
    if (dport == 16'd7) begin
      if (tx_busy) m_busy++;
      else if (len > 16'd1024 || mode != 0) m_bad++;
      else begin m_ok++; m_tx++; end
    end
    if (echo) begin
      e = '{flags: 3'b100, data: 32'h0, bv: 3'd0, ip: ip, dport: sport, len: len, follows: 0};
      exp_q.push_back(e);
      for (int i = 0; i < nb; i++) begin
        e.flags = 3'b010; e.data = w[i]; e.bv = (i == nb - 1) ? tail : 3'd4; e.follows = 1;
        exp_q.push_back(e);
      end
      e.flags = 3'b001; e.follows = 1;
      exp_q.push_back(e);
    end
    base = '0;
    base.dst_port = dport; base.src_ip = ip; base.src_port = sport; base.payload_len = len;
    dropped = 0;
    @(negedge clk);
    rx_drv = base;
    rx_drv.start = 1'b1;
    for (int i = 0; i < nsend; i++) begin
      if (mode == 2 && i >= cut) break;
      @(negedge clk);
      rx_drv = base;
      if ($urandom_range(0, 3) == 0) @(negedge clk);
      rx_drv.data_valid  = 1'b1;
      rx_drv.data        = w[i];
      rx_drv.bytes_valid = (i == nb - 1) ? tail : 3'd4;
      if (mode == 1 && i == cut) begin
        rx_drv.drop = 1'b1;
        dropped = 1;
        break;
      end
    end
    @(negedge clk);
    rx_drv = base;
    if (!dropped) rx_drv.commit = 1'b1;
    @(negedge clk);
    rx_drv = '0;
  endtask

  task automatic wait_drain(input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_dv(input int limit);
    UDPv4TxBus t;
    int n = 0;
    t = tx_bus;
    while (!t.data_valid && n < limit) begin
      @(negedge clk);
      t = tx_bus;
      n++;
    end
    if (!t.data_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_data_valid_timeout got=0 exp=1");
    end
  endtask

  // Let everything settle, then the responder must be idle.
  task automatic finish_dgram(input string name, input bit expect_no_busy);
    wait_drain(2000);
    repeat (12) @(negedge clk);
    check({name, "_busy_low"}, 64'(busy), 64'd0);
    if (expect_no_busy) check({name, "_busy_never"}, 64'(busy_seen), 64'd0);
    busy_seen = 0;
  endtask

  task automatic check_idle_outputs(input string name);
    checks++;
    if (tx_bus !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s got tx=%h busy=%b exp tx=0 busy=0", name, tx_bus, busy);
    end
  endtask

  initial begin : stim
    logic [15:0] dp, ln;
    int          md, ct, sel, nb;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset_state");
`ifdef UDP_ECHO_STATS_EN
    check("reset_stat_ok", 64'(s_ok), 64'd0);
    check("reset_stat_tx", 64'(s_tx), 64'd0);
`endif
    rst = 1'b0;
    repeat (2) @(negedge clk);
    busy_seen = 0;

    send_dgram(16'd7, 32'h0A000002, 16'd5000, 16'd8, 0, 0, 0, 1, 32'h01020304, 32'h05060708);
    finish_dgram("basic_len8", 0);
    send_dgram(16'd7, 32'h0A000003, 16'd5001, 16'd5, 0, 0, 0, 1, 32'hAABBCCDD, 32'hEE000000);
    finish_dgram("len5", 0);
    send_dgram(16'd7, 32'h0A000004, 16'd5002, 16'd0, 0, 0, 0, 0, 32'h0, 32'h0);
    finish_dgram("len0", 0);

    // Reset in the middle of a reply abandons it without a commit.
    send_dgram(16'd7, 32'h0A000005, 16'd6000, 16'd64, 0, 0, 0, 0, 32'h0, 32'h0);
    wait_dv(100);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_tx");
    exp_q.delete();
    m_ok = 0; m_busy = 0; m_bad = 0; m_tx = 0;
    rst = 1'b0;
    finish_dgram("after_reset", 0);
    send_dgram(16'd7, 32'h0A000006, 16'd6001, 16'd12, 0, 0, 0, 0, 32'h0, 32'h0);
    finish_dgram("fresh_after_reset", 0);

    send_dgram(16'd53, 32'h0A000007, 16'd7000, 16'd16, 0, 0, 0, 0, 32'h0, 32'h0);
    finish_dgram("wrong_port", 1);
    send_dgram(16'd7, 32'h0A000008, 16'd7001, 16'd1025, 0, 0, 0, 0, 32'h0, 32'h0);
    finish_dgram("oversize", 1);
    send_dgram(16'd7, 32'h0A000009, 16'd7002, 16'd16, 1, 2, 0, 0, 32'h0, 32'h0);
    send_dgram(16'd7, 32'h0A00000A, 16'd7003, 16'd4, 0, 0, 0, 0, 32'h0, 32'h0);
    finish_dgram("drop_then_ok", 0);
    send_dgram(16'd7, 32'h0A00000B, 16'd7004, 16'd8, 2, 1, 0, 0, 32'h0, 32'h0);
    finish_dgram("len_mismatch", 0);

    // A start arriving while a reply streams is ignored.
    send_dgram(16'd7, 32'h0A00000C, 16'd8000, 16'd80, 0, 0, 0, 0, 32'h0, 32'h0);
    wait_dv(100);
    send_dgram(16'd7, 32'h0A00000D, 16'd8001, 16'd8, 0, 0, 1, 0, 32'h0, 32'h0);
    finish_dgram("busy_ignore", 0);

    send_dgram(16'd7, 32'hC0A80101, 16'd9000, 16'd1024, 0, 0, 0, 0, 32'h0, 32'h0);
    finish_dgram("max_len", 0);

    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 15);
      dp  = (sel == 0) ? 16'd53 : 16'd7;
      sel = $urandom_range(0, 15);
      if (sel == 0)     ln = 16'(1025 + $urandom_range(0, 40));
      else if (sel < 3) ln = 16'($urandom_range(0, 1024));
      else              ln = 16'($urandom_range(0, 48));
      nb  = (int'(ln) + 3) / 4;
      md  = 0;
      ct  = 0;
      sel = $urandom_range(0, 9);
      if (ln > 0 && sel == 0) begin
        md = 1; ct = $urandom_range(0, nb - 1);
      end else if (ln > 4 && sel == 1) begin
        md = 2; ct = $urandom_range(0, nb - 1);
      end
      send_dgram(dp, $urandom, 16'($urandom), ln, md, ct, 0, 0, 32'h0, 32'h0);
      finish_dgram("random", (dp != 16'd7) || (ln > 16'd1024));
    end

`ifdef UDP_ECHO_STATS_EN
    check("stat_rx_ok", 64'(s_ok), 64'(m_ok));
    check("stat_rx_busy", 64'(s_busy), 64'(m_busy));
    check("stat_rx_bad", 64'(s_bad), 64'(m_bad));
    check("stat_tx", 64'(s_tx), 64'(m_tx));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
